// File: rtl/leaf_line_feeder_pkg.sv
// Shared constants and helpers for the leaf line feeder.
// The defaults here describe the reference configuration.
package leaf_feeder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LINE_WIDTH = 512;
  localparam int LEAF_CNT   = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 16;

  // Ceiling log2 with a floor of 1, so that every index vector has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        bits = i + 1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

  localparam int WORDS      = LINE_WIDTH / DATA_WIDTH;
  localparam int TAG_W      = clog2(LEAF_CNT);
  localparam int LINE_BYTES = LINE_WIDTH / 8;

endpackage

// File: rtl/leaf_line_feeder_if.sv
// Memory read channel of the feeder: a request stream and a credit-based response stream.
// The master side is the feeder; the slave side is the memory.
interface leaf_line_feeder_if #(
  parameter int ADDR_WIDTH = leaf_feeder_pkg::ADDR_WIDTH,
  parameter int TAG_W      = leaf_feeder_pkg::TAG_W,
  parameter int LINE_WIDTH = leaf_feeder_pkg::LINE_WIDTH
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic [TAG_W-1:0]      rd_req_tag;
  logic                  rd_resp_valid;
  logic [TAG_W-1:0]      rd_resp_tag;
  logic [LINE_WIDTH-1:0] rd_resp_data;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tag,
    input  rd_req_ready, rd_resp_valid, rd_resp_tag, rd_resp_data
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    output rd_req_ready, rd_resp_valid, rd_resp_tag, rd_resp_data
  );
endinterface

// File: rtl/leaf_line_queue.sv
// Per-leaf two-line buffer: holds returned lines, counts lines in flight and
// unpacks the head line one record per cycle into the leaf FIFO.
module leaf_line_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic                  i_issue,
  input  logic                  i_fifo_full,
  output logic                  o_write,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_credit,
  output logic                  o_inflight_nz,
  output logic                  o_empty
);
  import leaf_feeder_pkg::*;

  localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
  localparam int PTR_W = clog2(WORDS);

  logic [WORDS-1:0][DATA_WIDTH-1:0] line_q [2];
  logic [WORDS-1:0][DATA_WIDTH-1:0] line_d [2];
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [PTR_W-1:0] word_ptr_q, word_ptr_d;
  logic             head_valid;
  logic             pop;
  logic             tail;

  // Head presentation to the leaf FIFO and credit/status flags.
  always_comb begin
    head_valid    = (count_q != 2'd0);
    o_write       = head_valid & ~i_fifo_full;
    o_data        = head_valid ? line_q[head_q][word_ptr_q] : {DATA_WIDTH{1'b0}};
    pop           = o_write && (word_ptr_q == PTR_W'(WORDS - 1));
    tail          = head_q ^ count_q[0];
    o_credit      = (({1'b0, count_q} + {1'b0, inflight_q}) < 3'd2);
    o_inflight_nz = (inflight_q != 2'd0);
    o_empty       = (count_q == 2'd0);
  end

  // Next-state for storage, pointers and the occupancy/in-flight counters.
  always_comb begin
    line_d     = line_q;
    head_d     = head_q;
    word_ptr_d = word_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;

    if (i_push) begin
      line_d[tail] = i_line;
    end else begin
      line_d[tail] = line_q[tail];
    end

    if (o_write) begin
      word_ptr_d = pop ? {PTR_W{1'b0}} : word_ptr_q + PTR_W'(1);
      head_d     = pop ? ~head_q : head_q;
    end else begin
      word_ptr_d = word_ptr_q;
      head_d     = head_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({i_push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case ({i_issue, i_push})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < 2; e++) begin
        line_q[e] <= '0;
      end
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 2'd0;
      word_ptr_q <= {PTR_W{1'b0}};
    end else begin
      line_q     <= line_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      word_ptr_q <= word_ptr_d;
    end
  end

endmodule

// File: rtl/leaf_line_feeder.sv
// Feeds the merger-tree leaves: fetches each leaf's run line by line with a
// round-robin arbiter and unpacks returned lines into the leaf FIFOs.
module leaf_line_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int LEAF_CNT   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [LEAF_CNT*ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEAF_CNT*LEN_WIDTH-1:0]  i_len_lines,
  leaf_line_feeder_if.master             mem,
  input  logic [LEAF_CNT-1:0]            i_leaf_fifo_full,
  output logic [LEAF_CNT-1:0]            o_leaf_fifo_write,
  output logic [LEAF_CNT*DATA_WIDTH-1:0] o_leaf_fifo_data,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);
  import leaf_feeder_pkg::*;

  localparam int TAG_W      = clog2(LEAF_CNT);
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q      [LEAF_CNT];
  logic [ADDR_WIDTH-1:0] base_d      [LEAF_CNT];
  logic [LEN_WIDTH-1:0]  remaining_q [LEAF_CNT];
  logic [LEN_WIDTH-1:0]  remaining_d [LEAF_CNT];
  logic [LEN_WIDTH-1:0]  issued_q    [LEAF_CNT];
  logic [LEN_WIDTH-1:0]  issued_d    [LEAF_CNT];
  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic                  err_q, err_d;

  logic [LEAF_CNT-1:0] credit, inflight_nz, empty, eligible, drained, issue, push;
  logic                grant_found;
  logic [TAG_W-1:0]    grant_idx, scan_idx;
  logic                handshake, start_ok, all_drained;

  for (genvar l = 0; l < LEAF_CNT; l++) begin : g_leaf
    leaf_line_queue #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
    ) u_queue (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_push        (push[l]),
      .i_line        (mem.rd_resp_data),
      .i_issue       (issue[l]),
      .i_fifo_full   (i_leaf_fifo_full[l]),
      .o_write       (o_leaf_fifo_write[l]),
      .o_data        (o_leaf_fifo_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .o_credit      (credit[l]),
      .o_inflight_nz (inflight_nz[l]),
      .o_empty       (empty[l])
    );
  end

  // Per-leaf strobes: request issue, response demux, eligibility and drain status.
  always_comb begin
    handshake = req_valid_q & mem.rd_req_ready;
    start_ok  = i_start && (state_q != ST_RUN);
    for (int l = 0; l < LEAF_CNT; l++) begin
      issue[l]    = handshake && (req_tag_q == TAG_W'(l));
      push[l]     = mem.rd_resp_valid && (mem.rd_resp_tag == TAG_W'(l)) && inflight_nz[l];
      eligible[l] = (state_q == ST_RUN) && (remaining_q[l] != {LEN_WIDTH{1'b0}}) && credit[l];
      drained[l]  = (remaining_q[l] == {LEN_WIDTH{1'b0}}) && !inflight_nz[l] && empty[l];
    end
    all_drained = &drained;
    // A response for a leaf with nothing outstanding is dropped and flagged.
    err_d = err_q | (mem.rd_resp_valid & ~inflight_nz[mem.rd_resp_tag]);
  end

  // Round-robin arbiter: first eligible leaf at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < LEAF_CNT; i++) begin
      scan_idx = rr_ptr_q + TAG_W'(i);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Run FSM and per-leaf run bookkeeping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start_ok ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = all_drained ? ST_DONE : ST_RUN;
      ST_DONE: state_d = start_ok ? ST_RUN : ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    for (int l = 0; l < LEAF_CNT; l++) begin
      base_d[l]      = base_q[l];
      remaining_d[l] = remaining_q[l];
      issued_d[l]    = issued_q[l];
      if (start_ok) begin
        base_d[l]      = i_base_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
        remaining_d[l] = i_len_lines[l*LEN_WIDTH +: LEN_WIDTH];
        issued_d[l]    = {LEN_WIDTH{1'b0}};
      end else if (issue[l]) begin
        remaining_d[l] = remaining_q[l] - LEN_WIDTH'(1);
        issued_d[l]    = issued_q[l] + LEN_WIDTH'(1);
      end else begin
        issued_d[l] = issued_q[l];
      end
    end
  end

  // Request register: holds steady under backpressure, reloads only when empty
  // so the next grant always sees counters updated by the previous handshake.
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_tag_d   = req_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (handshake) begin
      req_valid_d = 1'b0;
      rr_ptr_d    = req_tag_q + TAG_W'(1);
    end else if (!req_valid_q && grant_found) begin
      req_valid_d = 1'b1;
      req_tag_d   = grant_idx;
      req_addr_d  = base_q[grant_idx]
                  + ADDR_WIDTH'(issued_q[grant_idx]) * ADDR_WIDTH'(LINE_BYTES);
    end else begin
      req_valid_d = req_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {TAG_W{1'b0}};
      req_valid_q <= 1'b0;
      req_addr_q  <= {ADDR_WIDTH{1'b0}};
      req_tag_q   <= {TAG_W{1'b0}};
      err_q       <= 1'b0;
      for (int l = 0; l < LEAF_CNT; l++) begin
        base_q[l]      <= {ADDR_WIDTH{1'b0}};
        remaining_q[l] <= {LEN_WIDTH{1'b0}};
        issued_q[l]    <= {LEN_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_tag_q   <= req_tag_d;
      err_q       <= err_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
    end
  end

  assign mem.rd_req_valid = req_valid_q;
  assign mem.rd_req_addr  = req_addr_q;
  assign mem.rd_req_tag   = req_tag_q;
  assign o_busy           = (state_q == ST_RUN);
  assign o_done           = (state_q == ST_DONE);
  assign o_err            = err_q;

endmodule

// File: tb/tb_leaf_line_feeder.sv
// Bench for leaf_line_feeder: a memory model answers requests in order after a
// short random latency; per-leaf scoreboards hold the records each leaf must receive.
module tb_leaf_line_feeder;

  localparam int L     = 8;
  localparam int AW    = 32;
  localparam int LW    = 16;
  localparam int DW    = 32;
  localparam int LINEW = 512;
  localparam int WORDS = 16;
  localparam int TW    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [L*AW-1:0]   i_base_addr;
  logic [L*LW-1:0]   i_len_lines;
  logic [L-1:0]      i_leaf_fifo_full;
  logic [L-1:0]      o_leaf_fifo_write;
  logic [L*DW-1:0]   o_leaf_fifo_data;
  logic              o_busy, o_done, o_err;

  leaf_line_feeder_if #(.ADDR_WIDTH(AW), .TAG_W(TW), .LINE_WIDTH(LINEW)) mem_if ();

  leaf_line_feeder #(
    .DATA_WIDTH (DW), .LINE_WIDTH (LINEW), .LEAF_CNT (L), .ADDR_WIDTH (AW), .LEN_WIDTH (LW)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (i_start),
    .i_base_addr       (i_base_addr),
    .i_len_lines       (i_len_lines),
    .mem               (mem_if),
    .i_leaf_fifo_full  (i_leaf_fifo_full),
    .o_leaf_fifo_write (o_leaf_fifo_write),
    .o_leaf_fifo_data  (o_leaf_fifo_data),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [AW-1:0] addr;
    int          due;
  } pend_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [31:0]   exp_q [L][$];
  pend_t         pend_q [$];
  int            hs_log [$];
  logic [AW-1:0] base_m  [L];
  int            issued_m[L];
  int            hs_cnt  [L];
  int            rec_cnt [L];
  int            lens    [L];
  int            bad_req = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rec_word(input logic [AW-1:0] a, input int w);
    return {a[27:0], w[3:0]};
  endfunction

  // One clock: at posedge+8 drive memory responses and observe what the next edge will do.
  task automatic tick();
    #7;
    mem_if.rd_resp_valid = 1'b0;
    mem_if.rd_resp_data  = '0;
    if (bad_req != 0) begin
      mem_if.rd_resp_valid = 1'b1;
      mem_if.rd_resp_tag   = 3'd5;
      mem_if.rd_resp_data  = '1;
      bad_req = 0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      pend_t p;
      p = pend_q.pop_front();
      mem_if.rd_resp_valid = 1'b1;
      mem_if.rd_resp_tag   = TW'(p.tag);
      for (int w = 0; w < WORDS; w++) mem_if.rd_resp_data[w*DW +: DW] = rec_word(p.addr, w);
    end
    if (mem_if.rd_req_valid) begin
      int t;
      t = int'(mem_if.rd_req_tag);
      chk("req_addr", 64'(mem_if.rd_req_addr), 64'(base_m[t] + AW'(issued_m[t] * 64)));
      if (mem_if.rd_req_ready) begin
        issued_m[t]++;
        hs_cnt[t]++;
        hs_log.push_back(t);
        pend_q.push_back('{t, mem_if.rd_req_addr, cyc + 2 + int'($urandom_range(0, 2))});
      end
    end
    for (int l = 0; l < L; l++) begin
      if (o_leaf_fifo_write[l]) begin
        if (i_leaf_fifo_full[l]) chk("wr_while_full", 64'd1, 64'd0);
        if (exp_q[l].size() == 0) chk($sformatf("unexpected_wr_leaf%0d", l), 64'd1, 64'd0);
        else chk($sformatf("rec_leaf%0d", l), 64'(o_leaf_fifo_data[l*DW +: DW]), 64'(exp_q[l].pop_front()));
        rec_cnt[l]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic [AW-1:0] run_base);
    for (int l = 0; l < L; l++) begin
      base_m[l]   = run_base + AW'(l) * 32'h0000_4000;
      issued_m[l] = 0;
      i_base_addr[l*AW +: AW] = base_m[l];
      i_len_lines[l*LW +: LW] = LW'(lens[l]);
      for (int n = 0; n < lens[l]; n++)
        for (int w = 0; w < WORDS; w++) exp_q[l].push_back(rec_word(base_m[l] + AW'(n * 64), w));
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000 && !o_done; i++) tick();
    chk({name, "_done"}, 64'(o_done), 64'd1);
    chk({name, "_busy_low"}, 64'(o_busy), 64'd0);
    for (int l = 0; l < L; l++) chk({name, "_drained"}, 64'(exp_q[l].size()), 64'd0);
    chk({name, "_no_pending"}, 64'(pend_q.size()), 64'd0);
  endtask

  task automatic set_lens(input int v);
    for (int l = 0; l < L; l++) lens[l] = v;
  endtask

  initial begin
    int hsb, r0b, r3b, h3b, r5b, r2b;
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len_lines = '0; i_leaf_fifo_full = '0;
    mem_if.rd_req_ready = 1'b1; mem_if.rd_resp_valid = 1'b0;
    mem_if.rd_resp_tag = '0; mem_if.rd_resp_data = '0;
    for (int l = 0; l < L; l++) begin issued_m[l] = 0; hs_cnt[l] = 0; rec_cnt[l] = 0; base_m[l] = '0; end
    #12;
    chk("rst_req_valid", 64'(mem_if.rd_req_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_write", 64'(o_leaf_fifo_write), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: one line per leaf, requests in tag order
    set_lens(1);
    hsb = hs_log.size();
    do_start(32'h1000_0000);
    chk("t1_busy", 64'(o_busy), 64'd1);
    wait_done("t1");
    chk("t1_nreq", 64'(hs_log.size() - hsb), 64'd8);
    if (hs_log.size() >= hsb + 8)
      for (int i = 0; i < 8; i++) chk("t1_order", 64'(hs_log[hsb + i]), 64'(i));

    // 2: backpressure holds the request steady
    mem_if.rd_req_ready = 1'b0;
    hsb = hs_log.size();
    do_start(32'h2000_0000);
    for (int i = 0; i < 20 && !mem_if.rd_req_valid; i++) tick();
    chk("t2_valid_seen", 64'(mem_if.rd_req_valid), 64'd1);
    chk("t2_tag0", 64'(mem_if.rd_req_tag), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(mem_if.rd_req_valid), 64'd1);
      chk("t2_hold_tag", 64'(mem_if.rd_req_tag), 64'd0);
    end
    chk("t2_no_hs", 64'(hs_log.size() - hsb), 64'd0);
    mem_if.rd_req_ready = 1'b1;
    tick();
    chk("t2_one_hs", 64'(hs_log.size() - hsb), 64'd1);
    for (int i = 0; i < 20 && !mem_if.rd_req_valid; i++) tick();
    chk("t2_next_tag", 64'(mem_if.rd_req_tag), 64'd1);
    wait_done("t2");

    // 3: leaf 3 blocked by a full FIFO
    set_lens(4);
    i_leaf_fifo_full = 8'b0000_1000;
    h3b = hs_cnt[3]; r3b = rec_cnt[3]; r0b = rec_cnt[0];
    do_start(32'h3000_0000);
    repeat (19) tick();
    chk("t3_leaf3_req_le2", 64'((hs_cnt[3] - h3b) <= 2), 64'd1);
    chk("t3_leaf3_nowr", 64'(rec_cnt[3] - r3b), 64'd0);
    chk("t3_leaf0_prog", 64'((rec_cnt[0] - r0b) > 0), 64'd1);
    i_leaf_fifo_full = '0;
    wait_done("t3");
    chk("t3_leaf3_recs", 64'(rec_cnt[3] - r3b), 64'd64);

    // 4: only leaf 2 has work
    set_lens(0); lens[2] = 2;
    hsb = hs_log.size(); r2b = rec_cnt[2];
    do_start(32'h4000_0000);
    wait_done("t4");
    chk("t4_nreq", 64'(hs_log.size() - hsb), 64'd2);
    if (hs_log.size() >= hsb + 2)
      for (int i = 0; i < 2; i++) chk("t4_tag", 64'(hs_log[hsb + i]), 64'd2);
    chk("t4_recs", 64'(rec_cnt[2] - r2b), 64'd32);

    // 5: stray response for an idle leaf
    chk("t5_err_pre", 64'(o_err), 64'd0);
    set_lens(1); lens[5] = 0;
    r5b = rec_cnt[5];
    do_start(32'h5000_0000);
    repeat (3) tick();
    bad_req = 1;
    repeat (3) tick();
    chk("t5_err_set", 64'(o_err), 64'd1);
    wait_done("t5");
    chk("t5_err_sticky", 64'(o_err), 64'd1);
    chk("t5_leaf5_nowr", 64'(rec_cnt[5] - r5b), 64'd0);

    // 6: asynchronous reset mid-run, then a clean restart
    set_lens(4);
    do_start(32'h6000_0000);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(mem_if.rd_req_valid), 64'd0);
    chk("t6_busy", 64'(o_busy), 64'd0);
    chk("t6_done", 64'(o_done), 64'd0);
    chk("t6_err", 64'(o_err), 64'd0);
    chk("t6_write", 64'(o_leaf_fifo_write), 64'd0);
    chk("t6_data", 64'(o_leaf_fifo_data == '0), 64'd1);
    pend_q.delete();
    for (int l = 0; l < L; l++) exp_q[l].delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    set_lens(2);
    hsb = hs_log.size();
    do_start(32'h7000_0000);
    wait_done("t6");
    if (hs_log.size() > hsb) chk("t6_first_tag", 64'(hs_log[hsb]), 64'd0);
    chk("t6_nreq", 64'(hs_log.size() - hsb), 64'd16);
    chk("t6_err_clear", 64'(o_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
